// File: rtl/stopwatch_dp_if.sv
// Control and display bundle between the stopwatch control unit (master)
// and the stopwatch datapath (slave).
interface stopwatch_dp_if;
  logic       i_runstop;
  logic       i_clear;
  logic       i_lap;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;
  logic       o_lap;

  modport master (
    output i_runstop, i_clear, i_lap,
    input  o_msec, o_sec, o_min, o_hour, o_tick, o_lap
  );

  modport slave (
    input  i_runstop, i_clear, i_lap,
    output o_msec, o_sec, o_min, o_hour, o_tick, o_lap
  );
endinterface

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: prescaler plus hh:mm:ss.hh counter cascade with registered display.
// Lap hold (display freeze while counting continues) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_dp #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_dp_if.slave  sw
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  // Out-of-range digits collapse to zero on any tick, and never carry.
  function automatic logic [6:0] digit_next(input logic [6:0] cur, input logic [6:0] max_v,
                                            input logic inc);
    logic [6:0] res;
    if (cur > max_v) begin
      res = 7'd0;
    end else if (inc) begin
      res = (cur == max_v) ? 7'd0 : cur + 7'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  logic [PW-1:0] presc_r;
  logic [6:0]    msec_r;
  logic [5:0]    sec_r;
  logic [5:0]    min_r;
  logic [4:0]    hour_r;

  logic       run_s;
  logic       tick_s;
  logic       c_sec_s;
  logic       c_min_s;
  logic       c_hour_s;
  logic [6:0] msec_nx_s;
  logic [6:0] sec_nx_s;
  logic [6:0] min_nx_s;
  logic [6:0] hour_nx_s;
  logic       hold_s;

  // Tick detection and next-digit values for the cascade
  always_comb begin
    run_s     = sw.i_runstop & ~sw.i_clear;
    tick_s    = run_s & (presc_r == PRESC_MAX);
    c_sec_s   = tick_s & (msec_r == 7'd99);
    c_min_s   = c_sec_s & (sec_r == 6'd59);
    c_hour_s  = c_min_s & (min_r == 6'd59);
    msec_nx_s = digit_next(msec_r, 7'd99, 1'b1);
    sec_nx_s  = digit_next({1'b0, sec_r}, 7'd59, c_sec_s);
    min_nx_s  = digit_next({1'b0, min_r}, 7'd59, c_min_s);
    hour_nx_s = digit_next({2'b00, hour_r}, 7'd23, c_hour_s);
  end

  // Prescaler and live counters; a paused prescaler keeps its fractional period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= '0;
      msec_r  <= 7'd0;
      sec_r   <= 6'd0;
      min_r   <= 6'd0;
      hour_r  <= 5'd0;
    end else if (sw.i_clear) begin
      presc_r <= '0;
      msec_r  <= 7'd0;
      sec_r   <= 6'd0;
      min_r   <= 6'd0;
      hour_r  <= 5'd0;
    end else if (run_s) begin
      if (tick_s) begin
        presc_r <= '0;
        msec_r  <= msec_nx_s;
        sec_r   <= sec_nx_s[5:0];
        min_r   <= min_nx_s[5:0];
        hour_r  <= hour_nx_s[4:0];
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_r;

  // Next lap state: toggled by i_lap, dropped by clear
  always_comb begin
    hold_s = ~sw.i_clear & (lap_r ^ sw.i_lap);
  end

  // Lap hold flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_r <= 1'b0;
    end else begin
      lap_r <= hold_s;
    end
  end

  assign sw.o_lap = lap_r;
`else
  logic unused_lap_s;

  assign hold_s       = 1'b0;
  assign sw.o_lap     = 1'b0;
  assign unused_lap_s = sw.i_lap;
`endif

  // Registered display; frozen while the lap hold is active
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw.o_tick <= 1'b0;
      sw.o_msec <= 7'd0;
      sw.o_sec  <= 6'd0;
      sw.o_min  <= 6'd0;
      sw.o_hour <= 5'd0;
    end else if (sw.i_clear) begin
      sw.o_tick <= 1'b0;
      sw.o_msec <= 7'd0;
      sw.o_sec  <= 6'd0;
      sw.o_min  <= 6'd0;
      sw.o_hour <= 5'd0;
    end else begin
      sw.o_tick <= tick_s;
      if (!hold_s) begin
        sw.o_msec <= msec_r;
        sw.o_sec  <= sec_r;
        sw.o_min  <= min_r;
        sw.o_hour <= hour_r;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_dp.sv
// Scoreboard bench for stopwatch_dp at CLK_FREQ=1000, TICK_HZ=100 (DIV=10).
// Expected display values are queued per tick; a monitor compares them one cycle after each o_tick.
module tb_stopwatch_dp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_dp_if sw_if();

  stopwatch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  logic        pend   = 1'b0;

  int          m_h, m_m, m_s, m_ms;
  logic        lap_m;
  logic [23:0] frozen;
  int          cnt, at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] pack(input int h, input int m, input int s, input int ms);
    return {h[4:0], m[5:0], s[5:0], ms[6:0]};
  endfunction

  function automatic logic [23:0] shown();
    return {sw_if.o_hour, sw_if.o_min, sw_if.o_sec, sw_if.o_msec};
  endfunction

  task automatic model_set(input int h, input int m, input int s, input int ms);
    m_h = h; m_m = m; m_s = s; m_ms = ms;
  endtask

  // Advance the reference clock k hundredths and queue what the display should show
  task automatic push_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      m_ms++;
      if (m_ms == 100) begin m_ms = 0; m_s++; end
      if (m_s == 60)   begin m_s = 0;  m_m++; end
      if (m_m == 60)   begin m_m = 0;  m_h++; end
      if (m_h == 24)   m_h = 0;
      exp_q.push_back(lap_m ? frozen : pack(m_h, m_m, m_s, m_ms));
    end
  endtask

  task automatic wait_tick(input int budget, output int pos);
    pos = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (sw_if.o_tick) begin
        pos = i;
        break;
      end
    end
  endtask

  // Monitor: display settles one cycle after o_tick
  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 32'(shown()), 32'hFFFF_FFFF);
        end else begin
          check("tick_display", 32'(shown()), 32'(exp_q.pop_front()));
        end
      end
      pend = sw_if.o_tick;
    end
  end

  initial begin
    rst = 1'b0;
    sw_if.i_runstop = 1'b0;
    sw_if.i_clear   = 1'b0;
    sw_if.i_lap     = 1'b0;
    lap_m  = 1'b0;
    frozen = 24'd0;
    model_set(0, 0, 0, 0);
    #2;
    check("reset_state", 32'({shown(), sw_if.o_tick, sw_if.o_lap}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 100 running clocks -> 10 ticks
    push_ticks(10);
    sw_if.i_runstop = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (sw_if.o_tick) cnt++;
    end
    sw_if.i_runstop = 1'b0;
    check("ticks_in_100", 32'(cnt), 32'd10);
    @(negedge clk);
    check("msec_after_100", 32'(sw_if.o_msec), 32'd10);
    check("sec_after_100", 32'(sw_if.o_sec), 32'd0);

    // Clear while held
    sw_if.i_clear = 1'b1;
    @(negedge clk);
    sw_if.i_clear = 1'b0;
    model_set(0, 0, 0, 0);
    check("clear_held", 32'(shown()), 32'd0);

    // Pause keeps the fractional prescaler period
    push_ticks(1);
    cnt = 0; at = -1;
    sw_if.i_runstop = 1'b1;
    repeat (5) begin @(negedge clk); if (sw_if.o_tick) cnt++; end
    sw_if.i_runstop = 1'b0;
    repeat (50) begin @(negedge clk); if (sw_if.o_tick) cnt++; end
    sw_if.i_runstop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (sw_if.o_tick) begin cnt++; at = i; end
    end
    sw_if.i_runstop = 1'b0;
    check("pause_tick_count", 32'(cnt), 32'd1);
    check("pause_tick_pos", 32'(at), 32'd5);
    @(negedge clk);
    check("pause_msec", 32'(sw_if.o_msec), 32'd1);

    // Clear while running at .37
    push_ticks(36);
    sw_if.i_runstop = 1'b1;
    repeat (365) @(negedge clk);
    check("msec_37", 32'(sw_if.o_msec), 32'd37);
    sw_if.i_clear = 1'b1;
    @(negedge clk);
    sw_if.i_clear = 1'b0;
    model_set(0, 0, 0, 0);
    check("clear_running", 32'({shown(), sw_if.o_tick}), 32'd0);
    push_ticks(1);
    wait_tick(15, at);
    sw_if.i_runstop = 1'b0;
    check("first_tick_after_clear", 32'(at), 32'd10);

    // Lap hold (display freezes only when the feature is built)
    push_ticks(19);
    sw_if.i_runstop = 1'b1;
    repeat (195) @(negedge clk);
    sw_if.i_lap = 1'b1;
`ifdef STOPWATCH_LAP_EN
    lap_m  = 1'b1;
    frozen = pack(m_h, m_m, m_s, m_ms);
`endif
    @(negedge clk);
    sw_if.i_lap = 1'b0;
    push_ticks(5);
    repeat (49) @(negedge clk);
`ifdef STOPWATCH_LAP_EN
    check("lap_frozen_msec", 32'(sw_if.o_msec), 32'd20);
    check("lap_flag_on", 32'(sw_if.o_lap), 32'd1);
`else
    check("nolap_live_msec", 32'(sw_if.o_msec), 32'd25);
    check("nolap_flag", 32'(sw_if.o_lap), 32'd0);
`endif
    sw_if.i_runstop = 1'b0;
    sw_if.i_lap     = 1'b1;
    @(negedge clk);
    sw_if.i_lap = 1'b0;
    lap_m = 1'b0;
    check("lap_release_msec", 32'(sw_if.o_msec), 32'd25);
    check("lap_flag_off", 32'(sw_if.o_lap), 32'd0);

    // Seconds-to-minutes carry from 00:00:59.99
    @(negedge clk);
    force dut.hour_r = 5'd0;  force dut.min_r = 6'd0;
    force dut.sec_r  = 6'd59; force dut.msec_r = 7'd99;
    @(negedge clk);
    release dut.hour_r; release dut.min_r; release dut.sec_r; release dut.msec_r;
    model_set(0, 0, 59, 99);
    push_ticks(1);
    sw_if.i_runstop = 1'b1;
    wait_tick(20, at);
    sw_if.i_runstop = 1'b0;
    check("min_carry_tick_seen", 32'(at > 0), 32'd1);
    @(negedge clk);

    // Day wrap from 23:59:59.99, then keep counting
    force dut.hour_r = 5'd23; force dut.min_r = 6'd59;
    force dut.sec_r  = 6'd59; force dut.msec_r = 7'd99;
    @(negedge clk);
    release dut.hour_r; release dut.min_r; release dut.sec_r; release dut.msec_r;
    model_set(23, 59, 59, 99);
    push_ticks(2);
    sw_if.i_runstop = 1'b1;
    wait_tick(15, at);
    check("wrap_tick_seen", 32'(at > 0), 32'd1);
    wait_tick(15, at);
    sw_if.i_runstop = 1'b0;
    check("post_wrap_tick_pos", 32'(at), 32'd10);
    @(negedge clk);

    // Out-of-range digits are zeroed on the next tick without carrying
    force dut.hour_r = 5'd0;  force dut.min_r = 6'd5;
    force dut.sec_r  = 6'd61; force dut.msec_r = 7'd120;
    @(negedge clk);
    release dut.hour_r; release dut.min_r; release dut.sec_r; release dut.msec_r;
    exp_q.push_back(pack(0, 5, 0, 0));
    sw_if.i_runstop = 1'b1;
    wait_tick(15, at);
    sw_if.i_runstop = 1'b0;
    check("range_tick_seen", 32'(at > 0), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-count at 00:00:03.45, clear and lap coincident
    force dut.hour_r = 5'd0; force dut.min_r = 6'd0;
    force dut.sec_r  = 6'd3; force dut.msec_r = 7'd45;
    @(negedge clk);
    release dut.hour_r; release dut.min_r; release dut.sec_r; release dut.msec_r;
    sw_if.i_runstop = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_time", 32'(shown()), 32'(pack(0, 0, 3, 45)));
    #2;
    rst = 1'b0;
    sw_if.i_clear = 1'b1;
    sw_if.i_lap   = 1'b1;
    #1;
    check("async_reset", 32'({shown(), sw_if.o_tick, sw_if.o_lap}), 32'd0);
    repeat (2) @(negedge clk);
    sw_if.i_clear = 1'b0;
    sw_if.i_lap   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_set(0, 0, 0, 0);
    push_ticks(1);
    wait_tick(15, at);
    sw_if.i_runstop = 1'b0;
    check("tick_after_reset", 32'(at), 32'd10);
    @(negedge clk);
    check("lap_after_reset", 32'(sw_if.o_lap), 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_dp.md
STOPWATCH_DP -- requirements
Module: stopwatch_dp

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count resolution in Hz; DIV = CLK_FREQ/TICK_HZ, integer, >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_runstop  input  1  run level from stopwatch control unit; 1 = count, 0 = hold.
REQ-006 SHALL have port i_clear  input  1  1-clk clear pulse from stopwatch control unit.
REQ-007 SHALL have port i_lap  input  1  1-clk lap toggle pulse; used only under STOPWATCH_LAP_EN.
REQ-008 SHALL have port o_msec  output  7  displayed hundredths, 0..99.
REQ-009 SHALL have port o_sec  output  6  displayed seconds, 0..59.
REQ-010 SHALL have port o_min  output  6  displayed minutes, 0..59.
REQ-011 SHALL have port o_hour  output  5  displayed hours, 0..23.
REQ-012 SHALL have port o_tick  output  1  1-clk pulse, cycle after each hundredths increment.
REQ-013 SHALL have port o_lap  output  1  1 while displayed value is frozen (lap hold).

Function
REQ-014 SHALL contain a prescaler counting 0..DIV-1, advancing only when i_runstop=1 and i_clear=0.
REQ-015 Prescaler SHALL hold its value (not reset) when i_runstop=0, so resume keeps the fractional period.
REQ-016 On the edge where prescaler=DIV-1 and running: prescaler -> 0, hundredths +1, o_tick=1 in the following cycle only.
REQ-017 Counter cascade SHALL be hundredths 0..99, sec 0..59, min 0..59, hour 0..23; each carry only when all lower digits at max on a tick edge.
REQ-018 23:59:59.99 plus one tick SHALL wrap to 00:00:00.00 with no flag and continue counting.
REQ-019 i_clear=1 SHALL, at that edge, zero prescaler, all counters, o_tick and o_lap, overriding run, tick and lap in the same cycle.
REQ-020 Clear SHALL NOT change run state; if i_runstop stays 1 counting restarts from 0 the next cycle.
REQ-021 Outputs SHALL be registered; live counter values appear on o_* the cycle after update (1-clk latency) when not in lap hold.
REQ-022 i_runstop toggling on the same edge as prescaler terminal SHALL use the sampled value: 1 -> tick occurs, 0 -> no tick, prescaler held.
REQ-023 Arithmetic SHALL never produce out-of-range digits; any out-of-range state SHALL be forced to 0 on the next tick.

Reset
REQ-024 rst=0 SHALL asynchronously set prescaler, all counters, o_msec/o_sec/o_min/o_hour=0, o_tick=0, o_lap=0.
REQ-025 Reset asserted mid-count SHALL discard all progress; after release counting starts from prescaler 0.
REQ-026 Reset release SHALL be sampled synchronously; first advance no earlier than the first edge after release.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN SHALL gate the lap-hold feature.
REQ-028 With STOPWATCH_LAP_EN defined: i_lap toggles o_lap; while o_lap=1, o_* freeze at the value at toggle time, internal counting continues; toggle off shows live value next cycle.
REQ-029 With STOPWATCH_LAP_EN undefined: i_lap ignored, o_lap tied 0, o_* always track live counters; no lap registers synthesized.

Verification (CLK_FREQ=1000, TICK_HZ=100, DIV=10)
REQ-030 Reset low, then high, i_runstop=1 for 100 clks -> 10 o_tick pulses, o_msec=10, o_sec=0.
REQ-031 Preload via run to 00:00:59.99, one more tick -> o_sec=0, o_min=1, o_msec=0; run to 23:59:59.99 plus tick -> all outputs 0.
REQ-032 Run 5 clks, i_runstop=0 for 50 clks, run 5 clks -> exactly one tick, at clk 10 of run time, o_msec=1.
REQ-033 Running at o_msec=37, i_clear pulse with i_runstop=1 -> next cycle all o_*=0, o_tick=0; first new tick 10 clks later.
REQ-034 LAP_EN: at o_msec=20 pulse i_lap, run 50 clks -> o_msec stays 20, o_lap=1; pulse i_lap -> o_msec=25 next cycle, o_lap=0.
REQ-035 Assert rst low mid-count at 00:00:03.45 -> outputs 0 immediately without clock edge; i_clear and i_lap coincident with reset have no effect.
